// File: rtl/systick_alarm.sv
// Memory-mapped millisecond alarm driven by systick's tick_count.
// Supports one-shot and drift-free periodic deadlines with a pending flag and irq.
module systick_alarm #(
   parameter logic [31:0] DEFAULT_PERIOD = 32'd1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] tick_count,
   output logic [31:0] data_bus_read,
   input  logic [31:0] data_bus_write,
   input  logic [31:0] data_bus_addr,
   input  logic        data_bus_select,
   input  logic [1:0]  data_bus_mode,
   output logic        irq
);

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } state_t;

   localparam logic [1:0] ADDR_CTRL     = 2'd0;
   localparam logic [1:0] ADDR_PERIOD   = 2'd1;
   localparam logic [1:0] ADDR_DEADLINE = 2'd2;
   localparam logic [1:0] ADDR_STATUS   = 2'd3;

   state_t      state_q, state_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] period_q, period_d;
   logic [31:0] deadline_q, deadline_d;
   logic        pending_q, pending_d;
   logic        overrun_q, overrun_d;
   logic        irq_q, irq_d;

   logic        bus_wr;
   logic [1:0]  reg_sel;
   logic [31:0] tick_delta;
   logic        due;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^{data_bus_addr[31:4], data_bus_addr[1:0]};

   assign reg_sel    = data_bus_addr[3:2];
   assign bus_wr     = data_bus_select && (data_bus_mode == 2'b10);
   // Sign of the wrapped difference keeps the comparison valid across rollover.
   assign tick_delta = tick_count - deadline_q;
   assign due        = (state_q == ARMED) && !tick_delta[31];

   always_comb begin
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      period_d   = period_q;
      deadline_d = deadline_q;
      pending_d  = pending_q;
      overrun_d  = overrun_q;
      irq_d      = pending_q & ctrl_q[2];

      if (bus_wr && reg_sel == ADDR_PERIOD) begin
         period_d = data_bus_write;
      end

      if (bus_wr && reg_sel == ADDR_STATUS) begin
         pending_d = pending_q & ~data_bus_write[0];
         overrun_d = overrun_q & ~data_bus_write[1];
      end

      // A CTRL write arms or disarms and takes priority over a fire in the same cycle.
      if (bus_wr && reg_sel == ADDR_CTRL) begin
         ctrl_d = data_bus_write[2:0];
         if (data_bus_write[0]) begin
            state_d    = ARMED;
            deadline_d = tick_count + period_q;
         end else begin
            state_d = IDLE;
         end
      end else if (due) begin
         pending_d = 1'b1;
         if (pending_q) begin
            overrun_d = 1'b1;
         end
         if (ctrl_q[1] && period_q != 32'd0) begin
            deadline_d = deadline_q + period_q;
         end else begin
            ctrl_d[0] = 1'b0;
            state_d   = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         ctrl_q     <= 3'b000;
         period_q   <= DEFAULT_PERIOD;
         deadline_q <= 32'd0;
         pending_q  <= 1'b0;
         overrun_q  <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         period_q   <= period_d;
         deadline_q <= deadline_d;
         pending_q  <= pending_d;
         overrun_q  <= overrun_d;
         irq_q      <= irq_d;
      end
   end

   always_comb begin
      data_bus_read = 32'd0;
      case (reg_sel)
         ADDR_CTRL:     data_bus_read = {29'd0, ctrl_q};
         ADDR_PERIOD:   data_bus_read = period_q;
         ADDR_DEADLINE: data_bus_read = deadline_q;
         ADDR_STATUS:   data_bus_read = {30'd0, overrun_q, pending_q};
         default:       data_bus_read = 32'd0;
      endcase
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_systick_alarm.sv
// Directed bench for systick_alarm: one-shot, periodic, wraparound, W1C races and reset.
// Expected values are hand-derived from the register map and firing rules.
module tb_systick_alarm;

   logic        clk;
   logic        reset;
   logic [31:0] tick_count;
   logic [31:0] data_bus_read;
   logic [31:0] data_bus_write;
   logic [31:0] data_bus_addr;
   logic        data_bus_select;
   logic [1:0]  data_bus_mode;
   logic        irq;

   int total_count = 0;
   int bad_count   = 0;

   systick_alarm #(.DEFAULT_PERIOD(32'd1000)) dut (
      .clk             (clk),
      .reset           (reset),
      .tick_count      (tick_count),
      .data_bus_read   (data_bus_read),
      .data_bus_write  (data_bus_write),
      .data_bus_addr   (data_bus_addr),
      .data_bus_select (data_bus_select),
      .data_bus_mode   (data_bus_mode),
      .irq             (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every action lands 1 time unit after a rising edge, away from the edge itself.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      total_count++;
      assert (observed === expected)
      else begin
         bad_count++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [1:0] reg_idx, input logic [31:0] value);
      data_bus_addr   = {28'd0, reg_idx, 2'b00};
      data_bus_write  = value;
      data_bus_mode   = 2'b10;
      data_bus_select = 1'b1;
      step();
      data_bus_select = 1'b0;
      data_bus_mode   = 2'b00;
   endtask

   task automatic check_reg(input string tag, input logic [1:0] reg_idx,
                            input logic [31:0] expected);
      data_bus_addr   = {28'd0, reg_idx, 2'b00};
      data_bus_mode   = 2'b01;
      data_bus_select = 1'b1;
      #1;
      check_output(tag, data_bus_read, expected);
      data_bus_select = 1'b0;
      data_bus_mode   = 2'b00;
   endtask

   task automatic advance_tick(input int n);
      for (int i = 0; i < n; i++) begin
         tick_count = tick_count + 32'd1;
         step();
      end
   endtask

   initial begin
      reset           = 1'b0;
      tick_count      = 32'd0;
      data_bus_write  = 32'd0;
      data_bus_addr   = 32'd0;
      data_bus_select = 1'b0;
      data_bus_mode   = 2'b00;
      step();
      step();
      reset = 1'b1;
      step();

      check_reg("rst_ctrl", 2'd0, 32'd0);
      check_reg("rst_period", 2'd1, 32'd1000);
      check_reg("rst_deadline", 2'd2, 32'd0);
      check_reg("rst_status", 2'd3, 32'd0);
      check_output("rst_irq", {31'd0, irq}, 32'd0);

      // One-shot: tick 100, period 5
      tick_count = 32'd100;
      apply_stimulus(2'd1, 32'd5);
      apply_stimulus(2'd0, 32'd1);
      check_reg("os_deadline", 2'd2, 32'd105);
      advance_tick(4);
      check_reg("os_no_fire_104", 2'd3, 32'd0);
      advance_tick(1);
      check_reg("os_fire_105", 2'd3, 32'd1);
      check_reg("os_ctrl_cleared", 2'd0, 32'd0);
      apply_stimulus(2'd3, 32'd1);
      check_reg("os_w1c", 2'd3, 32'd0);

      // Periodic with irq: tick 10, period 3
      tick_count = 32'd10;
      apply_stimulus(2'd1, 32'd3);
      apply_stimulus(2'd0, 32'd7);
      check_reg("per_deadline0", 2'd2, 32'd13);
      advance_tick(3);
      check_reg("per_fire13_dl", 2'd2, 32'd16);
      check_reg("per_fire13_st", 2'd3, 32'd1);
      check_output("per_irq_lag", {31'd0, irq}, 32'd0);
      advance_tick(1);
      check_output("per_irq_up", {31'd0, irq}, 32'd1);
      apply_stimulus(2'd3, 32'd1);
      check_output("per_irq_hold", {31'd0, irq}, 32'd1);
      step();
      check_output("per_irq_down", {31'd0, irq}, 32'd0);
      advance_tick(2);
      check_reg("per_fire16_dl", 2'd2, 32'd19);
      check_reg("per_fire16_st", 2'd3, 32'd1);
      advance_tick(3);
      check_reg("per_fire19_dl", 2'd2, 32'd22);
      check_reg("per_overrun", 2'd3, 32'd3);
      check_reg("per_ctrl_kept", 2'd0, 32'd7);
      apply_stimulus(2'd3, 32'd3);
      check_reg("per_w1c_both", 2'd3, 32'd0);
      apply_stimulus(2'd0, 32'd0);

      // Wraparound arm
      tick_count = 32'hFFFF_FFFE;
      apply_stimulus(2'd1, 32'd4);
      apply_stimulus(2'd0, 32'd1);
      check_reg("wrap_deadline", 2'd2, 32'd2);
      advance_tick(1);
      check_reg("wrap_no_ffff", 2'd3, 32'd0);
      advance_tick(1);
      check_reg("wrap_no_0", 2'd3, 32'd0);
      advance_tick(1);
      check_reg("wrap_no_1", 2'd3, 32'd0);
      advance_tick(1);
      check_reg("wrap_fire_2", 2'd3, 32'd1);
      check_reg("wrap_ctrl", 2'd0, 32'd0);
      apply_stimulus(2'd3, 32'd1);

      // W1C racing a fire: fire wins
      tick_count = 32'd50;
      apply_stimulus(2'd1, 32'd2);
      apply_stimulus(2'd0, 32'd1);
      advance_tick(1);
      tick_count = 32'd52;
      apply_stimulus(2'd3, 32'd1);
      check_reg("race_fire_wins", 2'd3, 32'd1);
      apply_stimulus(2'd3, 32'd1);
      check_reg("race_cleared", 2'd3, 32'd0);

      // Disarm while armed
      tick_count = 32'd60;
      apply_stimulus(2'd0, 32'd1);
      advance_tick(1);
      apply_stimulus(2'd0, 32'd0);
      advance_tick(2);
      check_reg("disarm_no_fire", 2'd3, 32'd0);

      // PERIOD write while armed affects only the next reload
      tick_count = 32'd70;
      apply_stimulus(2'd0, 32'd3);
      apply_stimulus(2'd1, 32'd5);
      check_reg("pw_deadline_kept", 2'd2, 32'd72);
      advance_tick(2);
      check_reg("pw_reload_new", 2'd2, 32'd77);
      apply_stimulus(2'd0, 32'd0);
      apply_stimulus(2'd3, 32'd3);

      // PERIOD=0 periodic arm fires once next cycle
      tick_count = 32'd80;
      apply_stimulus(2'd1, 32'd0);
      apply_stimulus(2'd0, 32'd3);
      step();
      check_reg("p0_fire", 2'd3, 32'd1);
      check_reg("p0_ctrl", 2'd0, 32'd2);
      apply_stimulus(2'd3, 32'd1);
      advance_tick(2);
      check_reg("p0_once", 2'd3, 32'd0);

      // Reset while armed with irq high
      tick_count = 32'd90;
      apply_stimulus(2'd1, 32'd1);
      apply_stimulus(2'd0, 32'd7);
      advance_tick(2);
      check_output("rstm_irq_before", {31'd0, irq}, 32'd1);
      reset = 1'b0;
      #1;
      check_output("rstm_irq", {31'd0, irq}, 32'd0);
      check_reg("rstm_ctrl", 2'd0, 32'd0);
      check_reg("rstm_period", 2'd1, 32'd1000);
      check_reg("rstm_status", 2'd3, 32'd0);
      reset = 1'b1;
      advance_tick(3);
      check_reg("rstm_no_fire", 2'd3, 32'd0);
      check_output("rstm_irq_after", {31'd0, irq}, 32'd0);

      $display("test done: total=%0d bad=%0d", total_count, bad_count);
      $finish;
   end

endmodule
